// File: rtl/dct_pkg.sv
// Shared definitions for the DCT back end: block geometry, the JPEG zigzag
// scan table and the zigzag read-FSM state type.
package dct_pkg;

  localparam int BLOCK_SIZE      = 64;
  localparam int PAIRS_PER_BLOCK = 32;

  // Raster index (row*8 + col) of the coefficient at each zigzag position.
  localparam logic [5:0] ZIGZAG_LUT [BLOCK_SIZE] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef enum logic {
    IDLE,
    STREAM
  } rd_state_t;

endpackage

// File: rtl/two_wide_zigzag_buf_if.sv
// AXI-Stream link carrying two coefficients per beat.
//   tdata  : {later coefficient, earlier coefficient}
//   tvalid : beat valid (master)
//   tready : sink ready (slave)
//   tlast  : final beat of an 8x8 block (master)
interface two_wide_zigzag_buf_if #(
  parameter int DATA_WIDTH = 8
);
  logic [2*DATA_WIDTH-1:0] tdata;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/zigzag_pingpong_ram.sv
// Two-bank coefficient store for the zigzag buffer.
//   i_clk          : write clock, rising edge
//   we             : write enable for one coefficient pair
//   wbank, wpair   : bank and pair index; pair k lands at words 2k and 2k+1
//   wdata0/wdata1  : even/odd word of the pair
//   rbank          : bank read by both ports
//   raddr0/raddr1  : asynchronous read addresses
//   rdata0/rdata1  : combinational read data
module zigzag_pingpong_ram
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  we,
  input  logic                  wbank,
  input  logic [ADDR_WIDTH-2:0] wpair,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  rbank,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1
);

  logic [DATA_WIDTH-1:0] mem [2][BLOCK_SIZE];

  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[wbank][{wpair, 1'b0}] <= wdata0;
      mem[wbank][{wpair, 1'b1}] <= wdata1;
    end
  end

  always_comb begin
    rdata0 = mem[rbank][raddr0];
    rdata1 = mem[rbank][raddr1];
  end

endmodule

// File: rtl/two_wide_zigzag_buf.sv
// Captures 8x8 DCT coefficient blocks arriving two per cycle in raster order
// and re-emits them two per beat in JPEG zigzag order on an AXI-Stream master.
// Ping-pong banks let the next block fill while the current one drains.
//   i_clk, i_resetn : clock (rising edge), asynchronous active-low reset
//   wdata0/wdata1   : coefficient pair, raster addresses 2k / 2k+1
//   wen             : pair valid; upstream cannot be stalled
//   m_axis          : zigzag output stream, {zz[2j+1], zz[2j]} per beat
//   o_overflow      : sticky, set when a whole block was dropped
module two_wide_zigzag_buf
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  wen,
  two_wide_zigzag_buf_if.master m_axis,
  output logic                  o_overflow
);

  if (ADDR_WIDTH != $clog2(BLOCK_SIZE)) begin : g_bad_addr_width
    $error("two_wide_zigzag_buf: zigzag table exists only for 64-entry blocks");
  end

  localparam int PW = ADDR_WIDTH - 1;

  logic [PW-1:0]         wptr;
  logic                  wbank;
  logic                  dropping;
  logic [1:0]            full;
  logic                  rbank;
  logic [PW-1:0]         rcnt;
  rd_state_t             state;

  logic                  drop_blk;
  logic                  wr_en;
  logic                  wr_done;
  logic                  rd_done;
  logic                  rd_load;
  logic [ADDR_WIDTH-1:0] raddr0;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;

  always_comb begin
    // The drop decision is taken on the first pair and then held for the
    // remaining 31 pairs of that block.
    drop_blk = (wptr == '0) ? full[wbank] : dropping;
    wr_en    = wen && !drop_blk;
    wr_done  = wr_en && (wptr == '1);
    rd_done  = (state == STREAM) && m_axis.tvalid && m_axis.tready && m_axis.tlast;
    // Once the tlast beat is in the register nothing more is loaded until it
    // is accepted.
    rd_load  = (state == STREAM) && !(m_axis.tvalid && m_axis.tlast) &&
               (!m_axis.tvalid || m_axis.tready);
    raddr0   = ZIGZAG_LUT[{rcnt, 1'b0}];
    raddr1   = ZIGZAG_LUT[{rcnt, 1'b1}];
  end

  zigzag_pingpong_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk  (i_clk),
    .we     (wr_en),
    .wbank  (wbank),
    .wpair  (wptr),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .rbank  (rbank),
    .raddr0 (raddr0),
    .raddr1 (raddr1),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wptr       <= '0;
      wbank      <= 1'b0;
      dropping   <= 1'b0;
      o_overflow <= 1'b0;
    end else if (wen) begin
      wptr     <= wptr + 1'b1;
      dropping <= drop_blk;
      if (drop_blk) o_overflow <= 1'b1;
      if (wr_done)  wbank <= ~wbank;
    end
  end

  // Write completion and read completion always target different banks, so
  // both updates can land on the same edge.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      full <= '0;
    end else begin
      if (wr_done) full[wbank] <= 1'b1;
      if (rd_done) full[rbank] <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state         <= IDLE;
      rbank         <= 1'b0;
      rcnt          <= '0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rbank]) begin
            state <= STREAM;
            rcnt  <= '0;
          end
        end
        STREAM: begin
          if (rd_done) begin
            rbank         <= ~rbank;
            rcnt          <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            state         <= full[~rbank] ? STREAM : IDLE;
          end else if (rd_load) begin
            m_axis.tdata  <= {rdata1, rdata0};
            m_axis.tvalid <= 1'b1;
            m_axis.tlast  <= (rcnt == '1);
            rcnt          <= rcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
